// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between a requester and alu_issue_ctrl.
// The master drives requests and consumes responses; the slave is the issue stage.
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [2:0]  req_src0;
  logic [2:0]  req_src1;
  logic [2:0]  req_dst;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;

  modport master (
    output req_valid, req_cmd, req_src0, req_src1, req_dst, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_src0, req_src1, req_dst, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage wrapped around an external combinational 16-bit ALU.
// Accepts a request, reads two operands from an 8x16 register file, drives the
// ALU from registers for one cycle, then writes the result back and holds it on
// the response handshake until the consumer takes it.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [2:0]        cmd_in,
  input  logic [DATA_W-1:0] alu_out,
  output logic [15:0]       op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] CMD_NOP = 3'b111;

  logic [1:0]        state_reg;
  logic [2:0]        dst_reg;
  logic [DATA_W-1:0] alu_in0_reg;
  logic [DATA_W-1:0] alu_in1_reg;
  logic [2:0]        cmd_in_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [15:0]       op_count_reg;
  logic [DATA_W-1:0] regfile_reg [NREGS];

  logic accept;
  logic writeback;

  // Handshake readiness depends only on the current state.
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = rsp_data_reg;

  assign alu_in0  = alu_in0_reg;
  assign alu_in1  = alu_in1_reg;
  assign cmd_in   = cmd_in_reg;
  assign op_count = op_count_reg;

  assign accept    = (state_reg == IDLE) && bus.req_valid;
  assign writeback = (state_reg == EXEC);

  // Sequencer: latch operands on accept, capture result after the EXEC cycle,
  // hold the response until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      dst_reg      <= '0;
      alu_in0_reg  <= '0;
      alu_in1_reg  <= '0;
      cmd_in_reg   <= CMD_NOP;
      rsp_data_reg <= '0;
      op_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_in0_reg <= regfile_reg[bus.req_src0];
            alu_in1_reg <= regfile_reg[bus.req_src1];
            cmd_in_reg  <= bus.req_cmd;
            dst_reg     <= bus.req_dst;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg <= alu_out;
          op_count_reg <= op_count_reg + 16'd1;
          state_reg    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Register file: each entry takes the ALU writeback first, otherwise a direct
  // load; a same-edge collision on one address therefore keeps the ALU result.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        regfile_reg[gi] <= '0;
      end else if (writeback && (dst_reg == 3'(gi))) begin
        regfile_reg[gi] <= alu_out;
      end else if (ld_en && (ld_addr == 3'(gi))) begin
        regfile_reg[gi] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU.
module tb_alu_issue_ctrl;

  localparam logic [2:0] C_INC = 3'b000, C_DEC = 3'b001, C_INV = 3'b010, C_RAND = 3'b011;
  localparam logic [2:0] C_ROR = 3'b100, C_ADD = 3'b101, C_SUB = 3'b110, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_in0, alu_in1, alu_out, op_count;
  logic [2:0]  cmd_in;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_count = 16'd0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .cmd_in   (cmd_in),
    .alu_out  (alu_out),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU feeding the DUT.
  always_comb begin
    alu_out = alu_in0;
    case (cmd_in)
      C_INC:   alu_out = alu_in0 + 16'd1;
      C_DEC:   alu_out = alu_in0 - 16'd1;
      C_INV:   alu_out = ~alu_in0;
      C_RAND:  alu_out = {15'd0, &alu_in0};
      C_ROR:   alu_out = {15'd0, |alu_in0};
      C_ADD:   alu_out = alu_in0 + alu_in1;
      C_SUB:   alu_out = alu_in0 - alu_in1;
      default: alu_out = alu_in0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // One full operation with RSP_READY held high; optional direct load placed on
  // the EXEC closing edge.
  task automatic do_op(input string tag, input logic [2:0] cmd, input logic [2:0] s0,
                       input logic [2:0] s1, input logic [2:0] d, input logic [15:0] exp,
                       input logic le, input logic [2:0] la, input logic [15:0] ldv);
    int n;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready"}, {15'd0, bus.req_ready}, 16'd1);
    bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_src0 = s0; bus.req_src1 = s1; bus.req_dst = d;
    tick();
    bus.req_valid = 1'b0;
    check_eq({tag, "_exec_vld"}, {15'd0, bus.rsp_valid}, 16'd0);
    ld_en = le; ld_addr = la; ld_data = ldv;
    tick();
    ld_en = 1'b0;
    exp_count = exp_count + 16'd1;
    check_eq({tag, "_vld"}, {15'd0, bus.rsp_valid}, 16'd1);
    check_eq({tag, "_data"}, bus.rsp_data, exp);
    check_eq({tag, "_cnt"}, op_count, exp_count);
    $display("op %s cmd=%b r%0d,r%0d->r%0d data=%h", tag, cmd, s0, s1, d, bus.rsp_data);
    tick();
    check_eq({tag, "_idle"}, {15'd0, bus.req_ready}, 16'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_src0 = '0; bus.req_src1 = '0;
    bus.req_dst = '0; bus.rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_ready", {15'd0, bus.req_ready}, 16'd1);
    check_eq("rst_valid", {15'd0, bus.rsp_valid}, 16'd0);
    check_eq("rst_cmd", {13'd0, cmd_in}, 16'd7);
    check_eq("rst_cnt", op_count, 16'd0);
    check_eq("rst_in0", alu_in0, 16'd0);
    check_eq("rst_data", bus.rsp_data, 16'd0);
    do_op("add0", C_ADD, 3'd0, 3'd0, 3'd1, 16'h0000, 1'b0, 3'd0, 16'h0);

    load(3'd1, 16'h1234);
    load(3'd2, 16'h0F0F);
    do_op("add", C_ADD, 3'd1, 3'd2, 3'd3, 16'h2143, 1'b0, 3'd0, 16'h0);
    check_eq("hold_in0", alu_in0, 16'h1234);
    do_op("nop", C_NOP, 3'd3, 3'd0, 3'd4, 16'h2143, 1'b0, 3'd0, 16'h0);

    load(3'd5, 16'hFFFF);
    do_op("inc", C_INC, 3'd5, 3'd0, 3'd5, 16'h0000, 1'b0, 3'd0, 16'h0);
    load(3'd1, 16'h0001);
    do_op("sub", C_SUB, 3'd5, 3'd1, 3'd6, 16'hFFFF, 1'b0, 3'd0, 16'h0);
    do_op("redand", C_RAND, 3'd6, 3'd0, 3'd7, 16'h0001, 1'b0, 3'd0, 16'h0);
    do_op("redor", C_ROR, 3'd0, 3'd0, 3'd7, 16'h0000, 1'b0, 3'd0, 16'h0);
    do_op("dec", C_DEC, 3'd0, 3'd0, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0);

    // Back-pressure: ADD r1(0x0001)+r2(0x0F0F)->r0 held for 5 cycles.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_cmd = C_ADD; bus.req_src0 = 3'd1; bus.req_src1 = 3'd2; bus.req_dst = 3'd0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    exp_count = exp_count + 16'd1;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_vld", {15'd0, bus.rsp_valid}, 16'd1);
      check_eq("stall_data", bus.rsp_data, 16'h0F10);
      check_eq("stall_ready", {15'd0, bus.req_ready}, 16'd0);
      bus.req_valid = (i == 2); bus.req_cmd = C_INC;
      tick();
    end
    bus.req_valid = 1'b0;
    check_eq("stall_cmd", {13'd0, cmd_in}, {13'd0, C_ADD});
    check_eq("stall_cnt", op_count, exp_count);
    $display("op stall data=%h", bus.rsp_data);
    bus.rsp_ready = 1'b1;
    tick();
    check_eq("release_ready", {15'd0, bus.req_ready}, 16'd1);
    check_eq("release_vld", {15'd0, bus.rsp_valid}, 16'd0);

    // Writeback/load collisions: same address keeps the ALU result, different
    // address takes both.
    load(3'd2, 16'hAAAA);
    do_op("inv_col", C_INV, 3'd2, 3'd0, 3'd3, 16'h5555, 1'b1, 3'd3, 16'hAAAA);
    do_op("nop_ld7", C_NOP, 3'd0, 3'd0, 3'd6, 16'h0F10, 1'b1, 3'd7, 16'h7777);
    do_op("rd_r3", C_NOP, 3'd3, 3'd0, 3'd4, 16'h5555, 1'b0, 3'd0, 16'h0);
    do_op("rd_r7", C_NOP, 3'd7, 3'd0, 3'd5, 16'h7777, 1'b0, 3'd0, 16'h0);
    do_op("rd_r6", C_NOP, 3'd6, 3'd0, 3'd5, 16'h0F10, 1'b0, 3'd0, 16'h0);

    // Reset during EXEC abandons the operation.
    load(3'd1, 16'h0042);
    bus.req_valid = 1'b1; bus.req_cmd = C_INC; bus.req_src0 = 3'd1; bus.req_src1 = 3'd0; bus.req_dst = 3'd1;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 16'd0;
    check_eq("mrst_cnt", op_count, 16'd0);
    check_eq("mrst_cmd", {13'd0, cmd_in}, 16'd7);
    check_eq("mrst_ready", {15'd0, bus.req_ready}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("mrst_vld", {15'd0, bus.rsp_valid}, 16'd0);
      tick();
    end
    $display("op midreset cnt=%h", op_count);
    do_op("rd_r1", C_NOP, 3'd1, 3'd0, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
